// File: rtl/cdc_pkg.sv
// Shared types and defaults for the req/ack CDC transmit controller.
package cdc_pkg;

   localparam int CDC_SYNC_STAGES    = 2;
   localparam int CDC_TIMEOUT_CYCLES = 1024;

   // ERR is only reachable when the watchdog is compiled in.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      ERR  = 2'd3
   } cdc_tx_state_t;

endpackage

// File: rtl/cdc_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; q is the last stage.
module cdc_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sff;

   always_ff @(posedge clk) begin
      if (rst) sff <= '0;
      else     sff <= {sff[STAGES-2:0], d};
   end

   assign q = sff[STAGES-1];

endmodule

// File: rtl/cdc_req_ack_tx.sv
// Source side of a four-phase req/ack word crossing.
// Optional per-phase watchdog and ERR state under `CDC_TIMEOUT_EN.
import cdc_pkg::*;

module cdc_req_ack_tx #(
   parameter int WIDTH          = 8,
   parameter int SYNC_STAGES    = CDC_SYNC_STAGES,
   parameter int TIMEOUT_CYCLES = CDC_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             ack_in,
   output logic             xfer_req,
   output logic [WIDTH-1:0] xfer_data,
   output logic             done,
   output logic             timeout_err,
   input  logic             err_clr
);

   cdc_tx_state_t state;
   logic          ack_sync;

   cdc_sync_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack_in),
      .q   (ack_sync)
   );

   assign in_ready = (state == IDLE);

`ifdef CDC_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;
   logic          tmo_hit;
   logic          tmo_err_q;

   // Counter holds the cycles already spent in this phase, so the phase
   // is abandoned on the edge that would make it TIMEOUT_CYCLES long.
   assign tmo_hit     = (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign timeout_err = tmo_err_q;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign timeout_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         xfer_req  <= 1'b0;
         xfer_data <= '0;
         done      <= 1'b0;
`ifdef CDC_TIMEOUT_EN
         cnt       <= '0;
         tmo_err_q <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef CDC_TIMEOUT_EN
         cnt <= (state == REQ || state == ACK) ? cnt + CW'(1) : '0;
`endif
         case (state)
            IDLE: if (in_valid) begin
               xfer_data <= in_data;
               xfer_req  <= 1'b1;
               state     <= REQ;
`ifdef CDC_TIMEOUT_EN
               cnt       <= '0;
`endif
            end
            // Ack transitions are checked before the watchdog so they win a tie.
            REQ: if (ack_sync) begin
               xfer_req <= 1'b0;
               state    <= ACK;
`ifdef CDC_TIMEOUT_EN
               cnt      <= '0;
            end else if (tmo_hit) begin
               xfer_req  <= 1'b0;
               tmo_err_q <= 1'b1;
               state     <= ERR;
               cnt       <= '0;
`endif
            end
            ACK: if (!ack_sync) begin
               done  <= 1'b1;
               state <= IDLE;
`ifdef CDC_TIMEOUT_EN
               cnt   <= '0;
            end else if (tmo_hit) begin
               tmo_err_q <= 1'b1;
               state     <= ERR;
               cnt       <= '0;
`endif
            end
`ifdef CDC_TIMEOUT_EN
            ERR: if (err_clr && !ack_sync) begin
               tmo_err_q <= 1'b0;
               state     <= IDLE;
               cnt       <= '0;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_req_ack_tx.sv
// Randomized bench for cdc_req_ack_tx; expected timing derived from ack delays.
`timescale 1ns/1ps
module tb_cdc_req_ack_tx;

   localparam int WIDTH = 8;
   localparam int S     = 2;
`ifdef CDC_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1024;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             ack_in;
   logic             xfer_req;
   logic [WIDTH-1:0] xfer_data;
   logic             done;
   logic             timeout_err;
   logic             err_clr;

   int n_chk = 0;
   int n_err = 0;
   logic [WIDTH-1:0] last_data;

   cdc_req_ack_tx #(.WIDTH(WIDTH), .SYNC_STAGES(S), .TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .ack_in      (ack_in),
      .xfer_req    (xfer_req),
      .xfer_data   (xfer_data),
      .done        (done),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag, input logic exp_done);
      chk({tag, ".in_ready"}, in_ready, 1);
      chk({tag, ".xfer_req"}, xfer_req, 0);
      chk({tag, ".done"}, done, exp_done);
      chk({tag, ".xfer_data"}, xfer_data, last_data);
      chk({tag, ".timeout_err"}, timeout_err, 0);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk_idle("idle", 0);
      end
   endtask

   // Caller has in_valid=1 / in_data=data set and the block idle. The
   // destination raises ack d1 edges after acceptance and drops it d2
   // edges after req falls. Acceptance is edge 0; req falls at edge
   // f = d1+S+1; done and in_ready come back at edge g = f+d2+S+1.
   task automatic run_xfer(input logic [WIDTH-1:0] data, input int d1, input int d2,
                           input logic nv, input logic [WIDTH-1:0] nd);
      int f, g;
      f = d1 + S + 1;
      g = f + d2 + S + 1;
      @(posedge clk); #1;
      in_valid = nv;
      in_data  = nv ? nd : WIDTH'($urandom);
      last_data = data;
      for (int k = 0; k <= g; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (k == d1) ack_in = 1'b1;
         if (k == f + d2) ack_in = 1'b0;
         @(negedge clk);
         chk("xfer.in_ready", in_ready, (k == g));
         chk("xfer.xfer_req", xfer_req, (k < f));
         chk("xfer.done", done, (k == g));
         chk("xfer.xfer_data", xfer_data, data);
         chk("xfer.timeout_err", timeout_err, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      logic [WIDTH-1:0] d, nd;
      logic             chain;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; ack_in = 1'b0; err_clr = 1'b0;
      last_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle("reset", 0);
      rst = 1'b0;
      idle(10);

      // Single word with zero-delay echo
      in_valid = 1'b1; in_data = 8'hA5;
      run_xfer(8'hA5, 0, 0, 1'b0, '0);
      idle(2);

      // Back-to-back with in_valid held high
      in_valid = 1'b1; in_data = 8'h01;
      run_xfer(8'h01, 0, 0, 1'b1, 8'h02);
      run_xfer(8'h02, 0, 0, 1'b1, 8'h03);
      run_xfer(8'h03, 0, 0, 1'b0, '0);
      idle(1);

      // Random words, destination delays and producer gaps
      d = WIDTH'($urandom);
      in_valid = 1'b1; in_data = d;
      for (int i = 0; i < 24; i++) begin
         chain = (i < 23) && ($urandom_range(0, 1) == 1);
         nd    = WIDTH'($urandom);
         run_xfer(d, $urandom_range(0, 5), $urandom_range(0, 5), chain, nd);
         if (!chain) begin
            idle($urandom_range(0, 3));
            nd = WIDTH'($urandom);
            in_valid = 1'b1; in_data = nd;
         end
         d = nd;
      end
      in_valid = 1'b0;
      idle(1);

      // Reset while in ACK (ack still held high by the destination)
      in_valid = 1'b1; in_data = 8'h77;
      @(posedge clk); #1;
      in_valid = 1'b0; ack_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1; ack_in = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      last_data = '0;
      chk_idle("rst_ack", 0);
      rst = 1'b0;
      in_valid = 1'b1; in_data = 8'h3C;
      run_xfer(8'h3C, 0, 0, 1'b0, '0);
      idle(2);

`ifdef CDC_TIMEOUT_EN
      // Watchdog: ack never arrives
      in_valid = 1'b1; in_data = 8'h5A;
      @(posedge clk); #1;
      in_valid = 1'b0;
      last_data = 8'h5A;
      for (int k = 0; k <= TMO + 3; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         @(negedge clk);
         chk("tmo.xfer_req", xfer_req, (k < TMO));
         chk("tmo.timeout_err", timeout_err, (k >= TMO));
         chk("tmo.in_ready", in_ready, 0);
         chk("tmo.xfer_data", xfer_data, 8'h5A);
      end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk_idle("tmo_clr", 0);
      in_valid = 1'b1; in_data = 8'hC3;
      run_xfer(8'hC3, 1, 2, 1'b0, '0);
`else
      // No watchdog: a 5000-cycle silent destination just stalls in REQ
      in_valid = 1'b1; in_data = 8'h5A;
      run_xfer(8'h5A, 5000, 1, 1'b0, '0);
`endif
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
